lcd_bus_timing_ctrl: RTL and testbench
======================================

Name: lcd_bus_timing_ctrl

Overview:
- Avalon-MM slave with waitrequest. Converts single-cycle CPU read/write requests into properly timed HD44780-style LCD bus cycles.
- Sits between the Nios interconnect and the LCD pins. It is the upstream, timing-correct stage that replaces direct combinational decode of address/read/write onto LCD_RS/LCD_RW/LCD_E.
- Generates address setup, E pulse width, hold and cycle recovery from clk-cycle counters.

Parameters:
- T_SETUP_CYC, 3: cycles RS/RW/data are stable before E rises (60 ns at 50 MHz).
- T_EHIGH_CYC, 12: cycles E is high (240 ns).
- T_HOLD_CYC, 2: cycles RS/RW/data are held after E falls (40 ns).
- T_RECOVER_CYC, 12: minimum E-low cycles after HOLD before the next bus cycle.
- CNT_W, 8: timing counter width. All T_* values must be in the range 1 to 2^CNT_W-1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- address, input, 2: bit0 = RW (1 = read), bit1 = RS (1 = data register).
- read, input, 1: Avalon read request.
- write, input, 1: Avalon write request.
- writedata, input, 8: write data.
- readdata, output, 8: registered read data.
- waitrequest, output, 1: Avalon waitrequest.
- LCD_E, output, 1: LCD enable, registered.
- LCD_RS, output, 1: LCD register select, registered.
- LCD_RW, output, 1: LCD read/write, registered.
- LCD_data, inout, 8: LCD data bus.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: state = IDLE, counter = 0, LCD_E = 0, LCD_RS = 0, LCD_RW = 1, LCD_data = Z, readdata = 0x00.
- Reset mid-operation: on the next edge all outputs return to reset values, E drops immediately and the pending transfer is abandoned. waitrequest follows its equation, so a master still holding read/write sees waitrequest = 1 until the transfer is rerun from IDLE.
- States:
  - IDLE → SETUP on (read|write). In that cycle capture RS = address[1]. Capture RW = address[0] & ~write (write wins if both are asserted; the address bit is otherwise ignored for writes). Capture wdata = writedata. Load counter.
  - SETUP lasts T_SETUP_CYC cycles, then → EHIGH.
  - EHIGH lasts T_EHIGH_CYC cycles. LCD_E = 1 exactly during EHIGH cycles. On the last EHIGH cycle, if RW = 1, register LCD_data into readdata. Then → HOLD.
  - HOLD lasts T_HOLD_CYC cycles, then → RECOVER.
  - RECOVER lasts T_RECOVER_CYC cycles, then → IDLE.
- Bus drive: LCD_data = wdata while RW = 0 in SETUP, EHIGH and HOLD; high-Z otherwise (always Z in IDLE and RECOVER). LCD_RS and LCD_RW change only on the IDLE→SETUP edge; LCD_RW returns to 1 on HOLD→RECOVER.
- waitrequest = (read|write) & ~done, combinational. done = 1 only in the last HOLD cycle. Requests arriving in RECOVER or during an active transfer see waitrequest = 1 and are held by the master.
- Latency: with the request present at cycle 0 in IDLE, waitrequest is low at cycle T_SETUP_CYC + T_EHIGH_CYC + T_HOLD_CYC (17 at defaults). readdata is valid in that cycle and holds until the next read completes.
- Minimum request-to-request period: 1 + T_SETUP_CYC + T_EHIGH_CYC + T_HOLD_CYC + T_RECOVER_CYC cycles (30 at defaults, i.e. 600 ns).
- Master signals are ignored after capture. Changes in address or writedata mid-transfer do not affect the pins.

Test Plan:
- Write: address = 2'b10, writedata = 0x41, write held until waitrequest = 0 → RS = 1, RW = 0 from cycle 1. LCD_data = 0x41 over cycles 1-17. E high exactly cycles 4-15. waitrequest low only at cycle 17. Bus Z at cycle 18.
- Read: address = 2'b01, read held; bench drives LCD_data = 0x80 during E high → RS = 0, RW = 1, bus never driven by the DUT. readdata = 0x80 at cycle 17 while waitrequest = 0.
- Back-to-back: second write asserted at cycle 18 → waitrequest stays 1 through RECOVER. Second E rise occurs at cycle 30 + 4 = 34. E-low gap between pulses ≥ 14 cycles.
- Reset mid-EHIGH: reset = 1 at cycle 8 → at cycle 9 E = 0, RW = 1, bus Z, readdata = 0x00, state IDLE. With read/write held, waitrequest stays 1 and the transfer reruns from IDLE with E rising 4 cycles after reset deasserts.
- read and write both asserted, address = 2'b11, writedata = 0x5A → executes as data write: RW = 0, bus = 0x5A, RS = 1.
- Parameter sweep T_SETUP_CYC = T_EHIGH_CYC = T_HOLD_CYC = T_RECOVER_CYC = 1 → E high for exactly 1 cycle. waitrequest low at cycle 3. Next IDLE at cycle 5.

Source files
------------

// File: rtl/lcd_bus_timing_ctrl.sv
// Avalon-MM slave that stretches single CPU requests into HD44780-style LCD bus cycles.
// Setup, E-high, hold and recovery phases are each timed by a shared down-counter.
`timescale 1ns/1ps

module lcd_bus_timing_ctrl #(
  parameter int unsigned T_SETUP_CYC   = 3,
  parameter int unsigned T_EHIGH_CYC   = 12,
  parameter int unsigned T_HOLD_CYC    = 2,
  parameter int unsigned T_RECOVER_CYC = 12,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_EHIGH   = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  localparam logic [CNT_W-1:0] LOAD_SETUP   = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_EHIGH   = CNT_W'(T_EHIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_HOLD    = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LOAD_RECOVER = CNT_W'(T_RECOVER_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              e_q, e_d;
  logic              rs_q, rs_d;
  logic              rw_q, rw_d;
  logic              drv_q, drv_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cnt_zero;
  logic              done;

  assign cnt_zero = (cnt_q == '0);
  assign done     = (state_q == ST_HOLD) && cnt_zero;

  // Handshake completes in the final hold cycle, so the master releases only after data is safe.
  assign waitrequest = (read | write) & ~done;

  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = rw_q;
  assign readdata = rdata_q;
  assign LCD_data = drv_q ? wdata_q : {DATA_W{1'bz}};

  // Next-state and next-output logic; pin registers only move on phase boundaries.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    rw_d    = rw_q;
    drv_d   = drv_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (read | write) begin
          state_d = ST_SETUP;
          cnt_d   = LOAD_SETUP;
          rs_d    = address[1];
          rw_d    = address[0] & ~write;
          drv_d   = write;
          wdata_d = writedata;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_EHIGH;
          cnt_d   = LOAD_EHIGH;
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_EHIGH: begin
        if (cnt_zero) begin
          state_d = ST_HOLD;
          cnt_d   = LOAD_HOLD;
          e_d     = 1'b0;
          if (rw_q) begin
            rdata_d = LCD_data;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_d = ST_RECOVER;
          cnt_d   = LOAD_RECOVER;
          rw_d    = 1'b1;
          drv_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        e_d     = 1'b0;
        rw_d    = 1'b1;
        drv_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rw_q    <= 1'b1;
      drv_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      drv_q   <= drv_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_lcd_bus_timing_ctrl.sv
// Directed bench for lcd_bus_timing_ctrl: default timing instance plus an all-ones timing instance.
// Undriven LCD bus lines are pulled up, so a released bus reads 0xFF.
`timescale 1ns/1ps

module tb_lcd_bus_timing_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] address;
  logic       read, write;
  logic [7:0] writedata;
  wire  [7:0] readdata;
  wire        waitrequest, lcd_e, lcd_rs, lcd_rw;
  wire  [7:0] lcd_bus;

  logic [1:0] s_address;
  logic       s_read, s_write;
  logic [7:0] s_writedata;
  wire  [7:0] s_readdata;
  wire        s_waitrequest, s_lcd_e, s_lcd_rs, s_lcd_rw;
  wire  [7:0] s_lcd_bus;

  logic       tb_drv;
  logic [7:0] tb_val;

  int n_cmp;
  int n_err;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (lcd_bus[i]);
    pullup (s_lcd_bus[i]);
  end

  // Model of the LCD answering a read while E is high.
  assign lcd_bus = (tb_drv && lcd_e) ? tb_val : 8'hzz;

  lcd_bus_timing_ctrl dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .LCD_E(lcd_e), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_data(lcd_bus)
  );

  lcd_bus_timing_ctrl #(
    .T_SETUP_CYC(1), .T_EHIGH_CYC(1), .T_HOLD_CYC(1), .T_RECOVER_CYC(1), .CNT_W(8)
  ) dut_min (
    .clk(clk), .reset(reset), .address(s_address), .read(s_read), .write(s_write),
    .writedata(s_writedata), .readdata(s_readdata), .waitrequest(s_waitrequest),
    .LCD_E(s_lcd_e), .LCD_RS(s_lcd_rs), .LCD_RW(s_lcd_rw), .LCD_data(s_lcd_bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (lcd_e !== 1'b0) begin n_err++; $display("FAIL rst_e got %b exp 0", lcd_e); end
    n_cmp++; if (lcd_rs !== 1'b0) begin n_err++; $display("FAIL rst_rs got %b exp 0", lcd_rs); end
    n_cmp++; if (lcd_rw !== 1'b1) begin n_err++; $display("FAIL rst_rw got %b exp 1", lcd_rw); end
    n_cmp++; if (lcd_bus !== 8'hFF) begin n_err++; $display("FAIL rst_bus got %h exp ff", lcd_bus); end
    n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata got %h exp 00", readdata); end
    n_cmp++; if (waitrequest !== 1'b0) begin n_err++; $display("FAIL rst_wait got %b exp 0", waitrequest); end
    n_cmp++; if (s_lcd_e !== 1'b0 || s_lcd_rw !== 1'b1) begin
      n_err++; $display("FAIL rst_min got e=%b rw=%b exp e=0 rw=1", s_lcd_e, s_lcd_rw);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_write();
    logic exp_e, exp_w, drop;
    logic [7:0] exp_bus;
    drop = 1'b0;
    @(posedge clk); #1;
    address = 2'b10; writedata = 8'h41; write = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (drop) begin write = 1'b0; drop = 1'b0; end
      end
      @(negedge clk);
      exp_e   = (c >= 4 && c <= 15);
      exp_w   = (c <= 17) ? (c != 17) : 1'b0;
      exp_bus = (c >= 1 && c <= 17) ? 8'h41 : 8'hFF;
      n_cmp++; if (lcd_e !== exp_e) begin n_err++; $display("FAIL wr_e c=%0d got %b exp %b", c, lcd_e, exp_e); end
      n_cmp++; if (waitrequest !== exp_w) begin n_err++; $display("FAIL wr_wait c=%0d got %b exp %b", c, waitrequest, exp_w); end
      n_cmp++; if (lcd_bus !== exp_bus) begin n_err++; $display("FAIL wr_bus c=%0d got %h exp %h", c, lcd_bus, exp_bus); end
      if (c >= 1) begin
        n_cmp++; if (lcd_rs !== 1'b1) begin n_err++; $display("FAIL wr_rs c=%0d got %b exp 1", c, lcd_rs); end
        n_cmp++; if (lcd_rw !== (c > 17)) begin n_err++; $display("FAIL wr_rw c=%0d got %b exp %b", c, lcd_rw, (c > 17)); end
      end
      if (waitrequest === 1'b0 && write) drop = 1'b1;
    end
  endtask

  task automatic test_read();
    logic exp_e, exp_w, drop;
    logic [7:0] exp_bus;
    drop = 1'b0;
    @(posedge clk); #1;
    address = 2'b01; read = 1'b1; tb_drv = 1'b1; tb_val = 8'h80;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (drop) begin read = 1'b0; drop = 1'b0; end
      end
      @(negedge clk);
      exp_e   = (c >= 4 && c <= 15);
      exp_w   = (c <= 17) ? (c != 17) : 1'b0;
      exp_bus = exp_e ? 8'h80 : 8'hFF;
      n_cmp++; if (lcd_e !== exp_e) begin n_err++; $display("FAIL rd_e c=%0d got %b exp %b", c, lcd_e, exp_e); end
      n_cmp++; if (waitrequest !== exp_w) begin n_err++; $display("FAIL rd_wait c=%0d got %b exp %b", c, waitrequest, exp_w); end
      n_cmp++; if (lcd_bus !== exp_bus) begin n_err++; $display("FAIL rd_bus c=%0d got %h exp %h", c, lcd_bus, exp_bus); end
      if (c >= 1) begin
        n_cmp++; if (lcd_rs !== 1'b0) begin n_err++; $display("FAIL rd_rs c=%0d got %b exp 0", c, lcd_rs); end
        n_cmp++; if (lcd_rw !== 1'b1) begin n_err++; $display("FAIL rd_rw c=%0d got %b exp 1", c, lcd_rw); end
      end
      if (c == 0) begin
        n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL rd_rdata_pre got %h exp 00", readdata); end
      end
      if (c >= 16) begin
        n_cmp++; if (readdata !== 8'h80) begin n_err++; $display("FAIL rd_rdata c=%0d got %h exp 80", c, readdata); end
      end
      if (waitrequest === 1'b0 && read) drop = 1'b1;
    end
    tb_drv = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic exp_e, exp_w, drop;
    drop = 1'b0;
    @(posedge clk); #1;
    address = 2'b01; read = 1'b1; tb_drv = 1'b1; tb_val = 8'h3C;
    for (int c = 0; c < 39; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 8) reset = 1'b1;
        if (c == 9) reset = 1'b0;
        if (drop) begin read = 1'b0; drop = 1'b0; end
      end
      @(negedge clk);
      exp_e = (c >= 4 && c <= 8) || (c >= 13 && c <= 24);
      exp_w = (c <= 26) ? (c != 26) : 1'b0;
      n_cmp++; if (lcd_e !== exp_e) begin n_err++; $display("FAIL rm_e c=%0d got %b exp %b", c, lcd_e, exp_e); end
      n_cmp++; if (waitrequest !== exp_w) begin n_err++; $display("FAIL rm_wait c=%0d got %b exp %b", c, waitrequest, exp_w); end
      if (c == 3) begin
        n_cmp++; if (readdata !== 8'h80) begin n_err++; $display("FAIL rm_rdata_hold got %h exp 80", readdata); end
      end
      if (c == 9) begin
        n_cmp++; if (lcd_rw !== 1'b1) begin n_err++; $display("FAIL rm_rw got %b exp 1", lcd_rw); end
        n_cmp++; if (lcd_bus !== 8'hFF) begin n_err++; $display("FAIL rm_bus got %h exp ff", lcd_bus); end
        n_cmp++; if (readdata !== 8'h00) begin n_err++; $display("FAIL rm_rdata_rst got %h exp 00", readdata); end
      end
      if (c == 26) begin
        n_cmp++; if (readdata !== 8'h3C) begin n_err++; $display("FAIL rm_rdata got %h exp 3c", readdata); end
      end
      if (waitrequest === 1'b0 && read) drop = 1'b1;
    end
    tb_drv = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp_e, exp_w, drop, prev_e;
    logic [7:0] exp_bus;
    int fall_c, rise_c;
    drop = 1'b0; prev_e = 1'b0; fall_c = -1; rise_c = -1;
    @(posedge clk); #1;
    address = 2'b00; writedata = 8'h11; write = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (drop) begin write = 1'b0; drop = 1'b0; end
        if (c == 5) begin writedata = 8'hEE; address = 2'b01; end
        if (c == 18) begin write = 1'b1; address = 2'b10; writedata = 8'h22; end
      end
      @(negedge clk);
      exp_e   = (c >= 4 && c <= 15) || (c >= 34 && c <= 45);
      exp_w   = (c == 17 || c >= 47) ? 1'b0 : 1'b1;
      exp_bus = (c >= 1 && c <= 17) ? 8'h11 : ((c >= 31 && c <= 47) ? 8'h22 : 8'hFF);
      n_cmp++; if (lcd_e !== exp_e) begin n_err++; $display("FAIL b2b_e c=%0d got %b exp %b", c, lcd_e, exp_e); end
      n_cmp++; if (waitrequest !== exp_w) begin n_err++; $display("FAIL b2b_wait c=%0d got %b exp %b", c, waitrequest, exp_w); end
      n_cmp++; if (lcd_bus !== exp_bus) begin n_err++; $display("FAIL b2b_bus c=%0d got %h exp %h", c, lcd_bus, exp_bus); end
      if (c >= 1) begin
        n_cmp++; if (lcd_rs !== (c >= 31)) begin n_err++; $display("FAIL b2b_rs c=%0d got %b exp %b", c, lcd_rs, (c >= 31)); end
        n_cmp++; if (lcd_rw !== !((c <= 17) || (c >= 31 && c <= 47))) begin
          n_err++; $display("FAIL b2b_rw c=%0d got %b", c, lcd_rw);
        end
      end
      if (prev_e && !lcd_e && fall_c < 0) fall_c = c;
      if (!prev_e && lcd_e && fall_c >= 0 && rise_c < 0) rise_c = c;
      prev_e = lcd_e;
      if (waitrequest === 1'b0 && write && c >= 40) drop = 1'b1;
      if (waitrequest === 1'b0 && write && c < 18) drop = 1'b1;
    end
    n_cmp++; if (rise_c != 34) begin n_err++; $display("FAIL b2b_rise got %0d exp 34", rise_c); end
    n_cmp++; if (fall_c < 0 || rise_c - fall_c < 14) begin
      n_err++; $display("FAIL b2b_gap got %0d exp >=14", rise_c - fall_c);
    end
  endtask

  task automatic test_both();
    logic exp_w, drop;
    drop = 1'b0;
    @(posedge clk); #1;
    address = 2'b11; writedata = 8'h5A; read = 1'b1; write = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (drop) begin read = 1'b0; write = 1'b0; drop = 1'b0; end
      end
      @(negedge clk);
      exp_w = (c <= 17) ? (c != 17) : 1'b0;
      n_cmp++; if (waitrequest !== exp_w) begin n_err++; $display("FAIL both_wait c=%0d got %b exp %b", c, waitrequest, exp_w); end
      if (c >= 1 && c <= 17) begin
        n_cmp++; if (lcd_rw !== 1'b0) begin n_err++; $display("FAIL both_rw c=%0d got %b exp 0", c, lcd_rw); end
        n_cmp++; if (lcd_rs !== 1'b1) begin n_err++; $display("FAIL both_rs c=%0d got %b exp 1", c, lcd_rs); end
        n_cmp++; if (lcd_bus !== 8'h5A) begin n_err++; $display("FAIL both_bus c=%0d got %h exp 5a", c, lcd_bus); end
      end
      if (c == 17) begin
        n_cmp++; if (readdata !== 8'h3C) begin n_err++; $display("FAIL both_rdata got %h exp 3c", readdata); end
      end
      if (waitrequest === 1'b0 && (read || write)) drop = 1'b1;
    end
  endtask

  task automatic test_min_timing();
    logic exp_e, exp_w;
    logic [7:0] exp_bus;
    @(posedge clk); #1;
    s_address = 2'b10; s_writedata = 8'h33; s_write = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 9) s_write = 1'b0;
      end
      @(negedge clk);
      exp_e   = (c == 2 || c == 7);
      exp_w   = (c <= 8) ? !(c == 3 || c == 8) : 1'b0;
      exp_bus = ((c >= 1 && c <= 3) || (c >= 6 && c <= 8)) ? 8'h33 : 8'hFF;
      n_cmp++; if (s_lcd_e !== exp_e) begin n_err++; $display("FAIL min_e c=%0d got %b exp %b", c, s_lcd_e, exp_e); end
      n_cmp++; if (s_waitrequest !== exp_w) begin n_err++; $display("FAIL min_wait c=%0d got %b exp %b", c, s_waitrequest, exp_w); end
      n_cmp++; if (s_lcd_bus !== exp_bus) begin n_err++; $display("FAIL min_bus c=%0d got %h exp %h", c, s_lcd_bus, exp_bus); end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; address = 2'b00; read = 1'b0; write = 1'b0; writedata = 8'h00;
    s_address = 2'b00; s_read = 1'b0; s_write = 1'b0; s_writedata = 8'h00;
    tb_drv = 1'b0; tb_val = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_reset_mid();
    test_back_to_back();
    test_both();
    test_min_timing();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
